// File: rtl/sequence_1010_detector_if.sv
// Serial bit-stream link for the 1010 detector: data bit towards the detector, match flag back.
interface sequence_1010_detector_if;
  logic in;
  logic detected;

  modport master (output in, input detected);
  modport slave (input in, output detected);
endinterface

// File: rtl/sequence_1010_detector.sv
// Moore FSM detecting the serial pattern 1-0-1-0 (oldest bit first), with
// elaboration-time choice of overlapping or restarting search after a match.
module sequence_1010_detector #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  sequence_1010_detector_if.slave     bus
);

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1010 = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   detected_q;

  // State and flag register; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      detected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      detected_q <= (state_d == S1010);
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.in ? S1   : IDLE;
      S1:      state_d = bus.in ? S1   : S10;
      S10:     state_d = bus.in ? S101 : IDLE;
      S101:    state_d = bus.in ? S1   : S1010;
      S1010: begin
        if (bus.in) state_d = OVERLAP ? S101 : S1;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.detected = detected_q;

endmodule

// File: tb/tb_sequence_1010_detector.sv
// Bench for sequence_1010_detector: overlapping and non-overlapping instances
// share one stimulus stream and are checked against a bit-history model.
module tb_sequence_1010_detector;

  logic clk;
  logic rst;
  logic din;

  sequence_1010_detector_if bus_ov ();
  sequence_1010_detector_if bus_no ();

  assign bus_ov.in = din;
  assign bus_no.in = din;

  sequence_1010_detector #(.OVERLAP(1'b1)) dut_ov (
    .clk (clk),
    .rst (rst),
    .bus (bus_ov.slave)
  );

  sequence_1010_detector #(.OVERLAP(1'b0)) dut_no (
    .clk (clk),
    .rst (rst),
    .bus (bus_no.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;

  // Reference: last four bits since reset, bit counts since reset and since last match.
  logic [3:0] hist = 4'b0;
  int         nbits = 0;
  int         since = 0;
  logic       exp_ov = 1'b0;
  logic       exp_no = 1'b0;

  task automatic step(input logic r, input logic b, input string tag);
    rst = r;
    din = b;
    @(posedge clk);
    if (!r) begin
      hist   = 4'b0;
      nbits  = 0;
      since  = 0;
      exp_ov = 1'b0;
      exp_no = 1'b0;
    end else begin
      hist   = {hist[2:0], b};
      nbits  = nbits + 1;
      since  = since + 1;
      exp_ov = (nbits >= 4) && (hist == 4'b1010);
      exp_no = (since >= 4) && (hist == 4'b1010);
      if (exp_no) since = 0;
    end
    #1;
    tests++;
    assert (bus_ov.detected === exp_ov) else begin
      fails++;
      $error("FAIL %s_ov observed=%b expected=%b", tag, bus_ov.detected, exp_ov);
    end
    tests++;
    assert (bus_no.detected === exp_no) else begin
      fails++;
      $error("FAIL %s_no observed=%b expected=%b", tag, bus_no.detected, exp_no);
    end
    @(negedge clk);
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], tag);
  endtask

  initial begin
    rst = 1'b0;
    din = 1'b0;
    @(negedge clk);

    // Reset then idle zeros
    step(1'b0, 1'b0, "reset");
    feed(16'b00000, 5, "idle_zeros");

    // 1101010: overlap pulses after bits 5 and 7, non-overlap only after bit 5
    step(1'b0, 1'b0, "rst_a");
    feed(16'b1101010, 7, "overlap");
    // Non-overlap needs a fresh 1010
    feed(16'b1010, 4, "fresh_1010");

    // Near-misses
    step(1'b0, 1'b0, "rst_b");
    feed(16'b10010110, 8, "near_miss");

    // Mid-pattern reset discards prefix
    step(1'b0, 1'b0, "rst_c");
    feed(16'b101, 3, "mid_prefix");
    step(1'b0, 1'b1, "mid_reset");
    feed(16'b0, 1, "mid_after");
    feed(16'b1010, 4, "mid_fresh");

    // Reset and completing bit on the same edge: reset wins, state restarts
    feed(16'b101, 3, "race_prefix");
    step(1'b0, 1'b0, "race_edge");
    feed(16'b010, 3, "race_after");
    feed(16'b1010, 4, "race_fresh");

    // Long runs
    feed(16'hFFFF, 16, "ones_run");
    feed(16'b0, 16, "zeros_run");

    // Randomized stream with occasional reset
    for (int k = 0; k < 400; k++) begin
      logic r;
      logic b;
      r = ($urandom_range(0, 24) != 0);
      b = 1'($urandom_range(0, 1));
      step(r, b, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
